fetch_unit: RTL

- Instruction fetch stage of the multicycle RV32I core, directly upstream of decode and the immediate generator.
- Owns the PC and issues one word-read at a time to instruction memory over a req/gnt + rvalid handshake.
- Latches the returned word into an instruction register and presents it, with its PC, to decode under a valid/ready handshake.
- Accepts branch/jump redirects from execute, squashing any in-flight fetch.

---
 rtl/core_pkg.sv | 16 +
 rtl/fetch_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multicycle RV32I core.
// Fetch FSM encoding and instruction-stream constants.
package core_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word-read at a time to
// instruction memory and hands the fetched word to decode under valid/ready.
module fetch_unit
    import core_pkg::*;
#(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,

    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic            instr_valid,
    input  logic            instr_ready,

    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,

    output logic [31:0]     fetch_count
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            valid_q, valid_d;
    logic [31:0]     count_q, count_d;
    logic            in_flight;

    // A request stays outstanding after this edge if it is granted now, or if
    // one was already pending and its data has not arrived yet.
    assign in_flight = ((state_q == REQ) && imem_gnt) ||
                       (((state_q == WAIT) || (state_q == DRAIN)) && !imem_rvalid);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        count_d  = count_q;

        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d  = imem_rdata;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + XLEN'(INSTR_BYTES);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything; any data or handshake this cycle is dropped.
        if (redirect) begin
            pc_d     = redirect_pc & ~XLEN'(3);
            instr_d  = instr_q;
            pc_out_d = pc_out_q;
            valid_d  = 1'b0;
            count_d  = count_q;
            state_d  = in_flight ? DRAIN : REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign fetch_count = count_q;

endmodule
